// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, FSM encoding and SRAM pin polarities for the async SRAM initiator.
`default_nettype none

package sram_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable down-counter that times the chip-select active window.
`default_nettype none

module sram_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule : sram_wait_cnt

`default_nettype wire

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: valid/ready initiator sequencing a 64x8 async SRAM through setup, access and hold.
`default_nettype none

module sram_async_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_cs_n,
  output logic              sram_rw_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  if ((ACCESS_CYC < 1) || (ACCESS_CYC > 15)) begin : g_bad_access_cyc
    $error("sram_async_ctrl: ACCESS_CYC must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYC - 1);

  state_t state;
  state_t state_nxt;
  logic   we_q;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  assign req_ready = (state == IDLE) & rst_n;

  sram_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(LOAD_VAL),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_load  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pins are registered one state ahead so address, data and RW settle before CS falls
  // and stay put until CS has risen again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_cs_n  <= CS_IDLE;
      sram_rw_en <= RW_READ;
      sram_addr  <= '0;
      sram_din   <= '0;
      we_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            sram_addr  <= req_addr;
            sram_din   <= req_wdata;
            we_q       <= req_we;
            sram_rw_en <= req_we ? RW_WRITE : RW_READ;
          end
        end
        SETUP: begin
          sram_cs_n <= CS_ACTIVE;
        end
        ACCESS: begin
          if (cnt_zero) begin
            sram_cs_n <= CS_IDLE;
            rsp_valid <= 1'b1;
            rsp_we    <= we_q;
            if (!we_q) begin
              rsp_rdata <= sram_dout;
            end
          end
        end
        HOLD: begin
          sram_rw_en <= RW_READ;
        end
        default: begin
          sram_cs_n <= CS_IDLE;
        end
      endcase
    end
  end

endmodule : sram_async_ctrl

`default_nettype wire
